// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants: write-back select encodings, link register index
// and register-file geometry used by control, pipeline registers and the regfile.
package wb_regfile_pkg;

  localparam int NUM_REGS         = 32;
  localparam int DATA_W           = 32;
  localparam int ADDR_W           = 5;
  localparam int RA_INDEX_DEFAULT = 31;

  typedef enum logic [1:0] {
    REGDST_RT     = 2'b00,
    REGDST_RD     = 2'b01,
    REGDST_RA     = 2'b10,
    REGDST_RT_ALT = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    MEM2REG_ALU     = 2'b00,
    MEM2REG_MEM     = 2'b01,
    MEM2REG_PC4     = 2'b10,
    MEM2REG_ALU_ALT = 2'b11
  } memtoreg_e;

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back select: resolves destination index, write data and effective
// write enable from the write-back stage control fields.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int RA_INDEX = RA_INDEX_DEFAULT
) (
  input  logic [DATA_W-1:0] PC_plus4,
  input  logic [DATA_W-1:0] Data_Mem_Out,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [1:0]        RegDst,
  input  logic              RegWr,
  input  logic [1:0]        MemToReg,
  input  logic [ADDR_W-1:0] RegisterRd,
  input  logic [ADDR_W-1:0] RegisterRt,
  output logic [ADDR_W-1:0] WB_Addr,
  output logic [DATA_W-1:0] WB_Data,
  output logic              WB_En
);

  localparam logic [ADDR_W-1:0] RA_ADDR = ADDR_W'(RA_INDEX);

  always_comb begin
    WB_Addr = RegisterRt;
    case (regdst_e'(RegDst))
      REGDST_RD:     WB_Addr = RegisterRd;
      REGDST_RA:     WB_Addr = RA_ADDR;
      default:       WB_Addr = RegisterRt;
    endcase
  end

  always_comb begin
    WB_Data = ALUOut;
    case (memtoreg_e'(MemToReg))
      MEM2REG_MEM:   WB_Data = Data_Mem_Out;
      MEM2REG_PC4:   WB_Data = PC_plus4;
      default:       WB_Data = ALUOut;
    endcase
  end

  // Register 0 is hard-wired; a write aimed at it is dropped here so neither
  // the array nor the bypass ever sees it.
  assign WB_En = RegWr && (WB_Addr != '0);

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with write-back select, synchronous active-low clear
// and same-cycle write-through bypass on both read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int RA_INDEX = RA_INDEX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC_plus4,
  input  logic [DATA_W-1:0] Data_Mem_Out,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [1:0]        RegDst,
  input  logic              RegWr,
  input  logic [1:0]        MemToReg,
  input  logic [ADDR_W-1:0] RegisterRd,
  input  logic [ADDR_W-1:0] RegisterRt,
  input  logic [ADDR_W-1:0] Read_register1,
  input  logic [ADDR_W-1:0] Read_register2,
  output logic [DATA_W-1:0] Read_data1,
  output logic [DATA_W-1:0] Read_data2,
  output logic [ADDR_W-1:0] WB_Addr,
  output logic [DATA_W-1:0] WB_Data,
  output logic              WB_En
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  wb_mux #(.RA_INDEX(RA_INDEX)) u_wb_mux (
    .PC_plus4     (PC_plus4),
    .Data_Mem_Out (Data_Mem_Out),
    .ALUOut       (ALUOut),
    .RegDst       (RegDst),
    .RegWr        (RegWr),
    .MemToReg     (MemToReg),
    .RegisterRd   (RegisterRd),
    .RegisterRt   (RegisterRt),
    .WB_Addr      (WB_Addr),
    .WB_Data      (WB_Data),
    .WB_En        (WB_En)
  );

  // Clear wins over a concurrent write; WB_En already excludes index 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WB_En) begin
      regs_q[WB_Addr] <= WB_Data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data,
    input logic [DATA_W-1:0] array_val
  );
    if (wb_en && (addr == wb_addr)) begin
      return wb_data;
    end else if (addr == '0) begin
      return '0;
    end else begin
      return array_val;
    end
  endfunction

  assign Read_data1 = read_port(Read_register1, WB_En, WB_Addr, WB_Data, regs_q[Read_register1]);
  assign Read_data2 = read_port(Read_register2, WB_En, WB_Addr, WB_Data, regs_q[Read_register2]);

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model of the register file.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] PC_plus4;
  logic [31:0] Data_Mem_Out;
  logic [31:0] ALUOut;
  logic [1:0]  RegDst;
  logic        RegWr;
  logic [1:0]  MemToReg;
  logic [4:0]  RegisterRd;
  logic [4:0]  RegisterRt;
  logic [4:0]  Read_register1;
  logic [4:0]  Read_register2;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic        WB_En;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  wb_regfile dut (
    .clk            (clk),
    .reset          (reset),
    .PC_plus4       (PC_plus4),
    .Data_Mem_Out   (Data_Mem_Out),
    .ALUOut         (ALUOut),
    .RegDst         (RegDst),
    .RegWr          (RegWr),
    .MemToReg       (MemToReg),
    .RegisterRd     (RegisterRd),
    .RegisterRt     (RegisterRt),
    .Read_register1 (Read_register1),
    .Read_register2 (Read_register2),
    .Read_data1     (Read_data1),
    .Read_data2     (Read_data2),
    .WB_Addr        (WB_Addr),
    .WB_Data        (WB_Data),
    .WB_En          (WB_En)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: destination and data straight from the encoding tables
  task automatic resolve(output logic [4:0] a, output logic [31:0] d, output logic e);
    if (RegDst == 2'b01)      a = RegisterRd;
    else if (RegDst == 2'b10) a = 5'd31;
    else                      a = RegisterRt;
    if (MemToReg == 2'b01)      d = Data_Mem_Out;
    else if (MemToReg == 2'b10) d = PC_plus4;
    else                        d = ALUOut;
    e = RegWr && (a != 5'd0);
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] r, input logic [4:0] a,
                                              input logic [31:0] d, input logic e);
    if (e && r == a) return d;
    return (r == 5'd0) ? 32'h0 : model[r];
  endfunction

  // driver tasks
  task automatic set_idle();
    RegWr = 1'b0; RegDst = 2'b00; MemToReg = 2'b00;
    RegisterRd = 5'd0; RegisterRt = 5'd0;
    PC_plus4 = 32'h0; Data_Mem_Out = 32'h0; ALUOut = 32'h0;
  endtask

  // advance one edge, updating the model exactly as the edge should
  task automatic tick();
    logic [4:0] a; logic [31:0] d; logic e;
    resolve(a, d, e);
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (e) begin
      model[a] = d;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    Read_register1 = 5'd0; Read_register2 = 5'd0;
    tick();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp_v;
      Read_register1 = 5'(i);
      Read_register2 = 5'(31 - i);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (Read_data1 !== exp_v) begin
        errors++;
        $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, Read_data1, exp_v);
      end
      checks++;
      if (Read_data2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", 31 - i, Read_data2, 32'h0);
      end
    end
  endtask

  task automatic test_bypass_then_array();
    set_idle();
    RegWr = 1'b1; RegDst = 2'b01; RegisterRd = 5'd5; MemToReg = 2'b00;
    ALUOut = 32'hDEADBEEF; Read_register1 = 5'd5; Read_register2 = 5'd6;
    #1;
    checks++;
    if (Read_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_rd1 got=%h exp=%h", Read_data1, 32'hDEADBEEF);
    end
    checks++;
    if (Read_data2 !== 32'h0) begin
      errors++; $display("FAIL bypass_other_port got=%h exp=%h", Read_data2, 32'h0);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (Read_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL array_rd1 got=%h exp=%h", Read_data1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_link();
    set_idle();
    RegWr = 1'b1; RegDst = 2'b10; MemToReg = 2'b10; PC_plus4 = 32'h0040_0010;
    ALUOut = 32'h1111_1111; RegisterRd = 5'd3; RegisterRt = 5'd4;
    #1;
    checks++;
    if (WB_Addr !== 5'd31) begin
      errors++; $display("FAIL link_addr got=%0d exp=%0d", WB_Addr, 31);
    end
    checks++;
    if (WB_Data !== 32'h0040_0010) begin
      errors++; $display("FAIL link_data got=%h exp=%h", WB_Data, 32'h0040_0010);
    end
    tick();
    set_idle();
    Read_register2 = 5'd31;
    #1;
    checks++;
    if (Read_data2 !== 32'h0040_0010) begin
      errors++; $display("FAIL link_array got=%h exp=%h", Read_data2, 32'h0040_0010);
    end
  endtask

  task automatic test_zero_dest();
    set_idle();
    RegWr = 1'b1; RegDst = 2'b00; RegisterRt = 5'd0; MemToReg = 2'b01;
    Data_Mem_Out = 32'h1234; Read_register1 = 5'd0; Read_register2 = 5'd0;
    #1;
    checks++;
    if (WB_En !== 1'b0) begin
      errors++; $display("FAIL zero_en got=%b exp=0", WB_En);
    end
    checks++;
    if (Read_data1 !== 32'h0 || Read_data2 !== 32'h0) begin
      errors++; $display("FAIL zero_bypass got=%h/%h exp=0/0", Read_data1, Read_data2);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (Read_data1 !== 32'h0) begin
      errors++; $display("FAIL zero_array got=%h exp=%h", Read_data1, 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    set_idle();
    reset = 1'b0;
    RegWr = 1'b1; RegDst = 2'b01; RegisterRd = 5'd7; ALUOut = 32'hFF;
    Read_register1 = 5'd7; Read_register2 = 5'd31;
    tick();
    RegWr = 1'b0;
    #1;
    checks++;
    if (Read_data1 !== 32'h0) begin
      errors++; $display("FAIL rstprio_r7 got=%h exp=%h", Read_data1, 32'h0);
    end
    checks++;
    if (Read_data2 !== 32'h0) begin
      errors++; $display("FAIL rstprio_r31 got=%h exp=%h", Read_data2, 32'h0);
    end
    reset = 1'b1;
    RegWr = 1'b1;
    tick();
    set_idle();
    #1;
    checks++;
    if (Read_data1 !== 32'hFF) begin
      errors++; $display("FAIL rstprio_resume got=%h exp=%h", Read_data1, 32'hFF);
    end
  endtask

  task automatic test_dual_bypass();
    set_idle();
    RegWr = 1'b1; RegDst = 2'b11; RegisterRt = 5'd9; RegisterRd = 5'd10;
    MemToReg = 2'b11; ALUOut = 32'hA5A5A5A5; Data_Mem_Out = 32'h5A5A5A5A;
    Read_register1 = 5'd9; Read_register2 = 5'd9;
    #1;
    checks++;
    if (Read_data1 !== 32'hA5A5A5A5 || Read_data2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL dual_bypass got=%h/%h exp=%h", Read_data1, Read_data2, 32'hA5A5A5A5);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a; logic [31:0] d; logic e;
      reset = ($urandom_range(0, 24) != 0);
      RegWr = $urandom_range(0, 3) != 0;
      RegDst = 2'($urandom_range(0, 3));
      MemToReg = 2'($urandom_range(0, 3));
      RegisterRd = 5'($urandom_range(0, 31));
      RegisterRt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ALUOut = $urandom; Data_Mem_Out = $urandom; PC_plus4 = $urandom;
      Read_register1 = 5'($urandom_range(0, 31));
      Read_register2 = ($urandom_range(0, 3) == 0) ? RegisterRd : 5'($urandom_range(0, 31));
      #1;
      resolve(a, d, e);
      checks++;
      if (WB_Addr !== a || WB_Data !== d || WB_En !== e) begin
        errors++;
        $display("FAIL rand_wb n=%0d got=%0d/%h/%b exp=%0d/%h/%b", n, WB_Addr, WB_Data, WB_En, a, d, e);
      end
      checks++;
      if (Read_data1 !== expect_read(Read_register1, a, d, e)) begin
        errors++;
        $display("FAIL rand_rd1 n=%0d got=%h exp=%h", n, Read_data1, expect_read(Read_register1, a, d, e));
      end
      checks++;
      if (Read_data2 !== expect_read(Read_register2, a, d, e)) begin
        errors++;
        $display("FAIL rand_rd2 n=%0d got=%h exp=%h", n, Read_data2, expect_read(Read_register2, a, d, e));
      end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b0;
    set_idle();
    Read_register1 = 5'd0; Read_register2 = 5'd0;
    @(negedge clk);
    test_reset();
    test_bypass_then_array();
    test_link();
    test_zero_dest();
    test_reset_priority();
    test_dual_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
